// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared state encodings and role constants for stage_ctrl
package stage_pkg;

  typedef enum logic [2:0] {
    S_MENU       = 3'd0,
    S_CONNECT    = 3'd1,
    S_GAME       = 3'd2,
    S_ROUND_OVER = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_e;

  localparam logic MASTER = 1'b0;
  localparam logic SLAVE  = 1'b1;

endpackage

// File: rtl/one_pulse.sv
// rtl/one_pulse.sv - registered rising-edge detector, one-cycle output pulse
module one_pulse (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // pulse when the input is high now but was low one cycle ago
  always_comb begin
    prev_d  = in;
    pulse_d = in & ~prev_q;
  end

  // edge history and registered pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - match-level stage controller for the two-board Sudoku game
module stage_ctrl
  import stage_pkg::*;
#(
  parameter int ROUNDS         = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RW             = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mouse_left,
  input  logic          on_start_btn,
  input  logic          on_connect_btn,
  input  logic          on_return_btn,
  input  logic          game_finish,
  input  logic          receive_connect,
  input  logic          receive_start,
  input  logic          receive_game_finish,
  output logic          send_connect,
  output logic          send_start,
  output logic          send_finish,
  output logic          connected,
  output logic          role,
  output logic          game_init,
  output logic [2:0]    state,
  output logic [RW-1:0] round_idx,
  output logic [RW-1:0] local_wins,
  output logic [RW-1:0] peer_wins,
  output logic          timeout_evt,
  output logic          link_lost_evt
);

  // a single-cycle timeout still needs a one-bit counter
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] LAST_RND  = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] WIN_MAX   = RW'(ROUNDS);
  localparam logic [RW-1:0] MAJ_LIMIT = RW'(ROUNDS / 2);

  state_e        state_q, state_d;
  logic          role_q, role_d;
  logic          connected_q, connected_d;
  logic          send_connect_q, send_connect_d;
  logic          send_start_q, send_start_d;
  logic          send_finish_q, send_finish_d;
  logic [RW-1:0] round_idx_q, round_idx_d;
  logic [RW-1:0] local_wins_q, local_wins_d;
  logic [RW-1:0] peer_wins_q, peer_wins_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_evt_q, timeout_evt_d;
  logic          link_lost_evt_q, link_lost_evt_d;

  logic click_pulse;
  logic start_pulse;
  logic link_drop_pulse;

  one_pulse u_click (
    .clk   (clk),
    .reset (reset),
    .in    (~mouse_left),
    .pulse (click_pulse)
  );

  one_pulse u_start (
    .clk   (clk),
    .reset (reset),
    .in    (receive_start),
    .pulse (start_pulse)
  );

  one_pulse u_link (
    .clk   (clk),
    .reset (reset),
    .in    (~receive_connect),
    .pulse (link_drop_pulse)
  );

  logic start_click, connect_click, return_click;
  logic local_fin, peer_fin, decided;

  // decode clicks by hovered button, and the per-cycle match decisions
  always_comb begin
    start_click   = click_pulse & on_start_btn;
    connect_click = click_pulse & on_connect_btn;
    return_click  = click_pulse & on_return_btn;
    local_fin     = game_finish;
    peer_fin      = receive_game_finish & connected_q;
    decided       = (round_idx_q == LAST_RND) ||
                    (local_wins_q > MAJ_LIMIT) ||
                    (peer_wins_q > MAJ_LIMIT);
  end

  // next-state and registered-output logic; link loss overrides everything
  always_comb begin
    state_d         = state_q;
    role_d          = role_q;
    connected_d     = connected_q;
    send_connect_d  = send_connect_q;
    send_finish_d   = send_finish_q;
    round_idx_d     = round_idx_q;
    local_wins_d    = local_wins_q;
    peer_wins_d     = peer_wins_q;
    tmo_cnt_d       = tmo_cnt_q;
    timeout_evt_d   = 1'b0;
    link_lost_evt_d = 1'b0;

    if (link_drop_pulse && connected_q) begin
      state_d         = S_MENU;
      connected_d     = 1'b0;
      send_connect_d  = 1'b0;
      role_d          = MASTER;
      send_finish_d   = 1'b0;
      round_idx_d     = '0;
      local_wins_d    = '0;
      peer_wins_d     = '0;
      tmo_cnt_d       = '0;
      link_lost_evt_d = 1'b1;
    end else begin
      case (state_q)
        S_MENU: begin
          if (!connected_q && receive_connect) begin
            role_d         = SLAVE;
            send_connect_d = 1'b1;
            connected_d    = 1'b1;
          end else if (!connected_q && connect_click) begin
            role_d         = MASTER;
            send_connect_d = 1'b1;
            tmo_cnt_d      = '0;
            state_d        = S_CONNECT;
          end else if ((role_q == MASTER && start_click) ||
                       (role_q == SLAVE && connected_q && start_pulse)) begin
            state_d       = S_GAME;
            round_idx_d   = '0;
            local_wins_d  = '0;
            peer_wins_d   = '0;
            send_finish_d = 1'b0;
          end
        end

        S_CONNECT: begin
          if (receive_connect) begin
            connected_d = 1'b1;
            state_d     = S_MENU;
          end else if (tmo_cnt_q == TMO_LAST) begin
            send_connect_d = 1'b0;
            timeout_evt_d  = 1'b1;
            tmo_cnt_d      = '0;
            state_d        = S_MENU;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end

        S_GAME: begin
          if (local_fin) begin
            send_finish_d = 1'b1;
          end
          if (local_fin && peer_fin) begin
            // simultaneous finish: the master's board takes the round
            if (role_q == MASTER) begin
              if (local_wins_q != WIN_MAX) local_wins_d = local_wins_q + RW'(1);
            end else begin
              if (peer_wins_q != WIN_MAX) peer_wins_d = peer_wins_q + RW'(1);
            end
            state_d = S_ROUND_OVER;
          end else if (local_fin) begin
            if (local_wins_q != WIN_MAX) local_wins_d = local_wins_q + RW'(1);
            state_d = S_ROUND_OVER;
          end else if (peer_fin) begin
            if (peer_wins_q != WIN_MAX) peer_wins_d = peer_wins_q + RW'(1);
            state_d = S_ROUND_OVER;
          end
        end

        S_ROUND_OVER: begin
          if (decided) begin
            if (return_click && (role_q == MASTER || connected_q)) begin
              state_d = S_MATCH_OVER;
            end
          end else if ((role_q == MASTER && return_click) ||
                       (role_q == SLAVE && connected_q && start_pulse)) begin
            if (round_idx_q != LAST_RND) round_idx_d = round_idx_q + RW'(1);
            send_finish_d = 1'b0;
            state_d       = S_GAME;
          end
        end

        S_MATCH_OVER: begin
          if (return_click) begin
            state_d       = S_MENU;
            round_idx_d   = '0;
            local_wins_d  = '0;
            peer_wins_d   = '0;
            send_finish_d = 1'b0;
          end
        end

        default: begin
          state_d = S_MENU;
        end
      endcase
    end

    // only the master drives start, and only while a round is in play
    send_start_d = (state_d == S_GAME) && (role_d == MASTER);
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_MENU;
      role_q          <= MASTER;
      connected_q     <= 1'b0;
      send_connect_q  <= 1'b0;
      send_start_q    <= 1'b0;
      send_finish_q   <= 1'b0;
      round_idx_q     <= '0;
      local_wins_q    <= '0;
      peer_wins_q     <= '0;
      tmo_cnt_q       <= '0;
      timeout_evt_q   <= 1'b0;
      link_lost_evt_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      role_q          <= role_d;
      connected_q     <= connected_d;
      send_connect_q  <= send_connect_d;
      send_start_q    <= send_start_d;
      send_finish_q   <= send_finish_d;
      round_idx_q     <= round_idx_d;
      local_wins_q    <= local_wins_d;
      peer_wins_q     <= peer_wins_d;
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_evt_q   <= timeout_evt_d;
      link_lost_evt_q <= link_lost_evt_d;
    end
  end

  assign send_connect  = send_connect_q;
  assign send_start    = send_start_q;
  assign send_finish   = send_finish_q;
  assign connected     = connected_q;
  assign role          = role_q;
  assign game_init     = (state_q != S_GAME);
  assign state         = state_q;
  assign round_idx     = round_idx_q;
  assign local_wins    = local_wins_q;
  assign peer_wins     = peer_wins_q;
  assign timeout_evt   = timeout_evt_q;
  assign link_lost_evt = link_lost_evt_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// tb/tb_stage_ctrl.sv - directed self-checking bench for stage_ctrl
module tb_stage_ctrl;

  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mouse_left, on_start_btn, on_connect_btn, on_return_btn;
  logic          game_finish, receive_connect, receive_start, receive_game_finish;
  logic          send_connect, send_start, send_finish, connected, role, game_init;
  logic [2:0]    state;
  logic [RW-1:0] round_idx, local_wins, peer_wins;
  logic          timeout_evt, link_lost_evt;

  int total = 0;
  int bad   = 0;

  stage_ctrl #(.ROUNDS(3), .TIMEOUT_CYCLES(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .mouse_left          (mouse_left),
    .on_start_btn        (on_start_btn),
    .on_connect_btn      (on_connect_btn),
    .on_return_btn       (on_return_btn),
    .game_finish         (game_finish),
    .receive_connect     (receive_connect),
    .receive_start       (receive_start),
    .receive_game_finish (receive_game_finish),
    .send_connect        (send_connect),
    .send_start          (send_start),
    .send_finish         (send_finish),
    .connected           (connected),
    .role                (role),
    .game_init           (game_init),
    .state               (state),
    .round_idx           (round_idx),
    .local_wins          (local_wins),
    .peer_wins           (peer_wins),
    .timeout_evt         (timeout_evt),
    .link_lost_evt       (link_lost_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = start, 1 = connect, 2 = return; state change is visible on return
  task automatic click(input int which);
    on_start_btn   = (which == 0);
    on_connect_btn = (which == 1);
    on_return_btn  = (which == 2);
    mouse_left = 1'b0;
    tick();
    mouse_left = 1'b1;
    tick();
    on_start_btn   = 1'b0;
    on_connect_btn = 1'b0;
    on_return_btn  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mouse_left = 1'b1;
    on_start_btn = 1'b0;
    on_connect_btn = 1'b0;
    on_return_btn = 1'b0;
    game_finish = 1'b0;
    receive_connect = 1'b0;
    receive_start = 1'b0;
    receive_game_finish = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;

    // reset values
    do_reset();
    check("rst_state", state, 0);
    check("rst_role", role, 0);
    check("rst_game_init", game_init, 1);
    check("rst_send_connect", send_connect, 0);
    check("rst_connected", connected, 0);
    check("rst_wins", {local_wins, peer_wins}, 0);

    // timeout: sixteen cycles in S_CONNECT then back to menu
    click(1);
    check("to_enter_state", state, 1);
    check("to_send_connect", send_connect, 1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state == 3'd1) n++;
      else break;
    end
    check("to_cycles", n, 16);
    check("to_evt", timeout_evt, 1);
    check("to_state", state, 0);
    check("to_send_connect_off", send_connect, 0);
    tick();
    check("to_evt_width", timeout_evt, 0);

    // slave join then peer start
    do_reset();
    receive_connect = 1'b1;
    tick();
    check("sj_role", role, 1);
    check("sj_connected", connected, 1);
    check("sj_send_connect", send_connect, 1);
    click(0);
    check("sj_start_click_ignored", state, 0);
    receive_start = 1'b1;
    tick();
    tick();
    check("sj_state", state, 2);
    check("sj_round", round_idx, 0);
    check("sj_send_start", send_start, 0);
    check("sj_game_init", game_init, 0);

    // solo master, majority after two wins
    do_reset();
    click(0);
    check("mw_state_game", state, 2);
    check("mw_send_start", send_start, 1);
    game_finish = 1'b1;
    tick();
    game_finish = 1'b0;
    check("mw_r0_state", state, 3);
    check("mw_r0_local", local_wins, 1);
    check("mw_r0_send_finish", send_finish, 1);
    check("mw_r0_send_start", send_start, 0);
    click(2);
    check("mw_r1_state", state, 2);
    check("mw_r1_round", round_idx, 1);
    check("mw_r1_send_finish", send_finish, 0);
    receive_game_finish = 1'b1;
    tick();
    receive_game_finish = 1'b0;
    check("mw_solo_peer_ignored", state, 2);
    game_finish = 1'b1;
    tick();
    game_finish = 1'b0;
    check("mw_r1_local", local_wins, 2);
    click(2);
    check("mw_match_over", state, 4);
    check("mw_round_kept", round_idx, 1);
    click(2);
    check("mw_menu", state, 0);
    check("mw_cleared", {local_wins, peer_wins, round_idx}, 0);

    // simultaneous finish as connected master
    do_reset();
    click(1);
    receive_connect = 1'b1;
    tick();
    check("sm_connected", connected, 1);
    check("sm_state_menu", state, 0);
    click(0);
    check("sm_state_game", state, 2);
    game_finish = 1'b1;
    receive_game_finish = 1'b1;
    tick();
    game_finish = 1'b0;
    receive_game_finish = 1'b0;
    check("sm_local", local_wins, 1);
    check("sm_peer", peer_wins, 0);
    check("sm_state", state, 3);

    // link loss in round 1 (continuing the master match)
    click(2);
    check("ll_round", round_idx, 1);
    check("ll_state_game", state, 2);
    receive_connect = 1'b0;
    tick();
    tick();
    check("ll_evt", link_lost_evt, 1);
    check("ll_state", state, 0);
    check("ll_connected", connected, 0);
    check("ll_counters", {local_wins, peer_wins, round_idx}, 0);
    check("ll_send", {send_connect, send_start, send_finish}, 0);
    tick();
    check("ll_evt_width", link_lost_evt, 0);

    // simultaneous finish as slave
    do_reset();
    receive_connect = 1'b1;
    tick();
    receive_start = 1'b1;
    tick();
    tick();
    check("ss_state_game", state, 2);
    game_finish = 1'b1;
    receive_game_finish = 1'b1;
    tick();
    game_finish = 1'b0;
    receive_game_finish = 1'b0;
    check("ss_peer", peer_wins, 1);
    check("ss_local", local_wins, 0);

    // asynchronous reset in S_ROUND_OVER
    do_reset();
    click(0);
    game_finish = 1'b1;
    tick();
    game_finish = 1'b0;
    check("rm_round_over", state, 3);
    #2;
    reset = 1'b1;
    #1;
    check("rm_state", state, 0);
    check("rm_wins", local_wins, 0);
    check("rm_send_finish", send_finish, 0);
    check("rm_game_init", game_init, 1);
    check("rm_role", role, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Match-level stage controller for the two-board Sudoku game. It sequences menu, peer connection, a multi-round match and the end-of-match screen for one board, and exchanges connect, start and finish levels with the peer board over the inter-board link. Compared with the single-round stage logic, it adds:
- a configurable best-of-N match;
- a connection timeout;
- link-loss recovery;
- deterministic tie-breaking for simultaneous finishes.

## Interface
Parameters:
- ROUNDS, 3: rounds per match, ≥1; match ends early on a majority.
- TIMEOUT_CYCLES, 50_000_000: cycles the master waits for the peer's connect before giving up.
- RW, $clog2(ROUNDS+1): width of round and win counters (derived, not overridden).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- mouse_left  in  1  raw left-button level; a click is its 1→0 edge
- on_start_btn / on_connect_btn / on_return_btn  in  1 each  cursor over that button
- game_finish  in  1  local board solved (level or pulse)
- receive_connect / receive_start / receive_game_finish  in  1 each  peer levels, already synchronised
- send_connect / send_start / send_finish  out  1 each  levels to the peer
- connected  out  1  link established
- role  out  1  0 = MASTER, 1 = SLAVE
- game_init  out  1  high outside S_GAME
- state  out  3  current state encoding
- round_idx  out  RW  current round, 0-based
- local_wins / peer_wins  out  RW  match score
- timeout_evt / link_lost_evt  out  1 each  one-cycle event pulses

## Operation
States: S_MENU=0, S_CONNECT=1, S_GAME=2, S_ROUND_OVER=3, S_MATCH_OVER=4. Other encodings go to S_MENU next cycle.

- **S_MENU, not connected:**
  - receive_connect=1: role←SLAVE, send_connect←1, connected←1.
  - Otherwise, connect click: role←MASTER, send_connect←1, load timeout counter, go to S_CONNECT.
  - Start click with role=MASTER starts a solo match, even when not connected.
- **S_CONNECT:**
  - receive_connect=1: connected←1, go to S_MENU.
  - Counter reaches TIMEOUT_CYCLES-1: send_connect←0, timeout_evt=1 for one cycle, go to S_MENU.
- **S_MENU, start:**
  - MASTER start click: go to S_GAME; round_idx, local_wins and peer_wins←0.
  - SLAVE (connected): rising edge of receive_start does the same. SLAVE start clicks are ignored.
- **S_GAME:**
  - send_start=1 while role=MASTER.
  - Local game_finish: local_wins+1, send_finish←1, go to S_ROUND_OVER.
  - receive_game_finish while connected: peer_wins+1, go to S_ROUND_OVER.
  - receive_game_finish while not connected: ignored.
  - Both finishes in the same cycle: the master's board wins. role=MASTER credits local_wins; role=SLAVE credits peer_wins. Exactly one counter increments.
- **S_ROUND_OVER:**
  - On entry: send_start←0, send_finish held.
  - The match is decided when round_idx==ROUNDS-1 or either win count > ROUNDS/2.
  - MASTER return click: if decided, go to S_MATCH_OVER; else round_idx+1, send_finish←0, go to S_GAME.
  - SLAVE, connected: not decided → rising edge of receive_start advances identically. Decided → a return click goes to S_MATCH_OVER.
- **S_MATCH_OVER:**
  - Return click: go to S_MENU, counters←0, send_finish←0.
  - connected, role and send_connect are kept.
- **Link loss:** receive_connect falling while connected, in any state:
  - connected←0, send_connect←0, role←MASTER;
  - link_lost_evt pulse;
  - go to S_MENU; counters, round_idx, send_start and send_finish←0.
  - Link loss has priority over every other transition in that cycle.
- **Widths:** win counters saturate at ROUNDS. round_idx never exceeds ROUNDS-1.

## Timing
- **Reset values:** state=S_MENU, role=MASTER, game_init=1, timeout counter=0. All other outputs (send_*, connected, counters, events) =0.
- **Click latency:** the click pulse is registered one cycle after the mouse_left 1→0 edge. The resulting state change is visible one further cycle later.
- **Other latencies:** all other input→state/output responses take exactly 1 clk. Edge detectors on receive_start and receive_connect add 1 register stage.
- **Event pulses:** exactly one cycle wide.
- **game_init:** combinational from state.
- **Reset mid-match:** returns to reset values asynchronously.

## Structure
- Package stage_pkg holds:
  - the state encodings;
  - the MASTER/SLAVE constants.
- Sub-module one_pulse(clk, reset, in, pulse): rising-edge detector, instantiated on ~mouse_left, receive_start and ~receive_connect.
- The timeout counter is inline, width $clog2(TIMEOUT_CYCLES).

## Test plan
Parameters: ROUNDS=3, TIMEOUT_CYCLES=16.
- **Timeout:** connect click, receive_connect held 0 → S_CONNECT for exactly 16 cycles, then timeout_evt for one cycle, send_connect=0, state=0.
- **Slave join:** receive_connect=1 in S_MENU → role=1, connected=1 after 1 cycle. receive_start rising → state=2, round_idx=0.
- **Majority win:** solo master, game_finish twice with one return click between → local_wins=2, and the second return click gives state=4 without playing round 2.
- **Simultaneous finish:** connected, game_finish and receive_game_finish in the same cycle → master: local_wins=1, peer_wins=0. Same stimulus as slave: peer_wins=1, local_wins=0.
- **Link loss:** drop receive_connect in S_GAME round 1 → link_lost_evt one cycle, state=0, connected=0, counters=0.
- **Reset mid-match:** assert reset in S_ROUND_OVER → all outputs at reset values immediately.
